// File: rtl/frame_pack.sv
// frame_pack: collects a serial sample stream into an overlapping frame
// and hands each full frame to the consumer when it reports empty.
module frame_pack #(
    parameter int DW        = 16,
    parameter int FRAME_LEN = 20,
    parameter int HOP       = 10,
    parameter int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    s_valid,
    input  logic [DW-1:0]           s_data,
    output logic                    s_ready,
    input  logic                    frame_empty,
    output logic                    frame_valid,
    output logic [FRAME_LEN*DW-1:0] frame_data,
    output logic [CW-1:0]           fill_level,
    output logic [15:0]             frame_cnt
);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    localparam int KEEP = FRAME_LEN - HOP;

    state_t        state_q;
    logic [DW-1:0] buf_q [FRAME_LEN];
    logic [CW-1:0] fill_q;
    logic [15:0]   cnt_q;
    logic          valid_q;

    // Accept only while filling; a flush cycle never swallows a sample.
    assign s_ready = (state_q == FILL) && !flush;

    // Element 1 (oldest) sits in the lowest DW bits of the bus.
    for (genvar g = 0; g < FRAME_LEN; g++) begin : g_flat
        assign frame_data[g*DW +: DW] = buf_q[g];
    end

    assign frame_valid = valid_q;
    assign fill_level  = fill_q;
    assign frame_cnt   = cnt_q;

    // Fill/hold FSM: sample capture, frame hand-over and overlap shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            fill_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            for (int k = 0; k < FRAME_LEN; k++) begin
                buf_q[k] <= '0;
            end
        end else if (flush) begin
            state_q <= FILL;
            fill_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            for (int k = 0; k < FRAME_LEN; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            unique case (state_q)
                FILL: begin
                    if (s_valid) begin
                        buf_q[fill_q] <= s_data;
                        fill_q        <= fill_q + CW'(1);
                        if (fill_q == CW'(FRAME_LEN - 1)) begin
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (frame_empty) begin
                        // Keep the newest samples as overlap, clear the rest.
                        for (int k = 0; k < KEEP; k++) begin
                            buf_q[k] <= buf_q[k+HOP];
                        end
                        for (int k = KEEP; k < FRAME_LEN; k++) begin
                            buf_q[k] <= '0;
                        end
                        fill_q  <= CW'(KEEP);
                        cnt_q   <= cnt_q + 16'd1;
                        valid_q <= 1'b0;
                        state_q <= FILL;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_pack.sv
// tb_frame_pack: scoreboard bench for frame_pack, covering the default
// overlap instance and a no-overlap (HOP=FRAME_LEN) instance.
module tb_frame_pack;

    localparam int DW = 16;
    localparam int FL = 20;
    localparam int CW = $clog2(FL + 1);

    typedef logic [FL*DW-1:0] frame_t;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          frame_empty;

    logic          rdy_a, rdy_b;
    logic          fv_a, fv_b;
    frame_t        fd_a, fd_b;
    logic [CW-1:0] fl_a, fl_b;
    logic [15:0]   fc_a, fc_b;

    logic          sel;
    logic          rdy_m, fv_m;
    frame_t        fd_m;
    logic [CW-1:0] fl_m;
    logic [15:0]   fc_m;

    int tests;
    int fails;

    frame_t        exp_q [$];
    logic [DW-1:0] win_q [$];

    frame_pack #(.DW(DW), .FRAME_LEN(FL), .HOP(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_a),
        .frame_empty(frame_empty), .frame_valid(fv_a),
        .frame_data(fd_a), .fill_level(fl_a), .frame_cnt(fc_a)
    );

    frame_pack #(.DW(DW), .FRAME_LEN(FL), .HOP(20)) u_dut20 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_b),
        .frame_empty(frame_empty), .frame_valid(fv_b),
        .frame_data(fd_b), .fill_level(fl_b), .frame_cnt(fc_b)
    );

    assign rdy_m = sel ? rdy_b : rdy_a;
    assign fv_m  = sel ? fv_b  : fv_a;
    assign fd_m  = sel ? fd_b  : fd_a;
    assign fl_m  = sel ? fl_b  : fl_a;
    assign fc_m  = sel ? fc_b  : fc_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference window: the samples the selected instance should hold.
    function automatic frame_t win_frame();
        frame_t f;
        f = '0;
        for (int k = 0; k < win_q.size(); k++) begin
            f[k*DW +: DW] = win_q[k];
        end
        return f;
    endfunction

    task automatic model_xfer();
        int hop;
        hop = sel ? 20 : 10;
        repeat (hop) void'(win_q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        flush       = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        frame_empty = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        win_q.delete();
        exp_q.delete();
    endtask

    // Feed n consecutive values from first; gaps adds random idle cycles.
    task automatic feed(input int first, input int n, input bit gaps);
        int i;
        int waits;
        i = 0;
        waits = 0;
        while (i < n) begin
            @(negedge clk);
            if (gaps && $urandom_range(1) == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = DW'(first + i);
                #1;
                if (rdy_m) begin
                    win_q.push_back(DW'(first + i));
                    if (win_q.size() == FL) exp_q.push_back(win_frame());
                    i++;
                    waits = 0;
                end else begin
                    waits++;
                    if (waits > 100) begin
                        tests++;
                        fails++;
                        $display("FAIL feed_timeout sample=%0d ready=%0b required=1",
                                 first + i, rdy_m);
                        i = n;
                    end
                end
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // At a negedge with a full frame: compare it against the scoreboard.
    task automatic check_frame(input string name);
        frame_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s no expected frame queued, got valid=%0b", name, fv_m);
        end else begin
            e = exp_q.pop_front();
            if (fv_m !== 1'b1 || fd_m !== e) begin
                fails++;
                $display("FAIL %s valid=%0b data=%h required valid=1 data=%h",
                         name, fv_m, fd_m, e);
            end
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        tests++;
        if (fv_a !== 1'b0 || fd_a !== '0 || fl_a !== '0 || fc_a !== '0 || rdy_a !== 1'b1) begin
            fails++;
            $display("FAIL reset_a fv=%0b fd=%h fl=%0d fc=%0d rdy=%0b required 0,0,0,0,1",
                     fv_a, fd_a, fl_a, fc_a, rdy_a);
        end
        tests++;
        if (fv_b !== 1'b0 || fd_b !== '0 || fl_b !== '0 || fc_b !== '0 || rdy_b !== 1'b1) begin
            fails++;
            $display("FAIL reset_b fv=%0b fd=%h fl=%0d fc=%0d rdy=%0b required 0,0,0,0,1",
                     fv_b, fd_b, fl_b, fc_b, rdy_b);
        end
    endtask

    task automatic test_basic();
        frame_t e;
        feed(1, 20, 1'b0);
        tests++;
        if (fl_m !== CW'(20) || rdy_m !== 1'b0) begin
            fails++;
            $display("FAIL basic_full fill=%0d rdy=%0b required 20,0", fl_m, rdy_m);
        end
        check_frame("basic_frame_1_20");
        @(negedge clk);
        model_xfer();
        e = win_frame();
        tests++;
        if (fv_m !== 1'b0 || fc_m !== 16'd1 || fl_m !== CW'(10) ||
            rdy_m !== 1'b1 || fd_m !== e) begin
            fails++;
            $display("FAIL basic_xfer fv=%0b cnt=%0d fill=%0d rdy=%0b data=%h required 0,1,10,1 data=%h",
                     fv_m, fc_m, fl_m, rdy_m, fd_m, e);
        end
    endtask

    task automatic test_hold();
        frame_t held;
        frame_empty = 1'b0;
        feed(21, 10, 1'b0);
        held = fd_m;
        for (int c = 0; c < 5; c++) begin
            s_valid = 1'b1;
            s_data  = 16'hdead;
            @(negedge clk);
            tests++;
            if (rdy_m !== 1'b0 || fv_m !== 1'b1 || fd_m !== held || fl_m !== CW'(20)) begin
                fails++;
                $display("FAIL hold_cycle%0d rdy=%0b fv=%0b fill=%0d data=%h required 0,1,20 data=%h",
                         c, rdy_m, fv_m, fl_m, fd_m, held);
            end
        end
        s_valid     = 1'b0;
        frame_empty = 1'b1;
        check_frame("hold_frame_11_30");
        @(negedge clk);
        model_xfer();
        tests++;
        if (fv_m !== 1'b0 || fc_m !== 16'd2 || fl_m !== CW'(10)) begin
            fails++;
            $display("FAIL hold_xfer fv=%0b cnt=%0d fill=%0d required 0,2,10",
                     fv_m, fc_m, fl_m);
        end
    endtask

    task automatic test_no_overlap();
        sel = 1'b1;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            feed(1 + 20*f, 20, 1'b0);
            check_frame(f == 0 ? "hop20_frame_1_20" : "hop20_frame_21_40");
            @(negedge clk);
            model_xfer();
            tests++;
            if (fv_m !== 1'b0 || fl_m !== '0 || fd_m !== '0 || fc_m !== 16'(f + 1)) begin
                fails++;
                $display("FAIL hop20_xfer%0d fv=%0b fill=%0d cnt=%0d data=%h required 0,0,%0d data=0",
                         f, fv_m, fl_m, fc_m, fd_m, f + 1);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        feed(1, 7, 1'b0);
        tests++;
        if (fl_m !== CW'(7)) begin
            fails++;
            $display("FAIL flush_pre fill=%0d required 7", fl_m);
        end
        flush = 1'b1;
        #1;
        tests++;
        if (rdy_m !== 1'b0) begin
            fails++;
            $display("FAIL flush_ready rdy=%0b required 0", rdy_m);
        end
        @(negedge clk);
        flush = 1'b0;
        win_q.delete();
        tests++;
        if (fl_m !== '0 || fd_m !== '0 || fc_m !== '0 || fv_m !== 1'b0) begin
            fails++;
            $display("FAIL flush_clear fill=%0d cnt=%0d fv=%0b data=%h required all 0",
                     fl_m, fc_m, fv_m, fd_m);
        end
        feed(100, 20, 1'b0);
        tests++;
        if (fc_m !== 16'd0) begin
            fails++;
            $display("FAIL flush_cnt_before cnt=%0d required 0", fc_m);
        end
        check_frame("flush_frame_100_119");
        @(negedge clk);
        model_xfer();
        tests++;
        if (fc_m !== 16'd1) begin
            fails++;
            $display("FAIL flush_cnt_after cnt=%0d required 1", fc_m);
        end
        feed(120, 10, 1'b0);
        check_frame("flush_xfer_frame_110_129");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        win_q.delete();
        tests++;
        if (fc_m !== 16'd0 || fv_m !== 1'b0 || fl_m !== '0 || fd_m !== '0) begin
            fails++;
            $display("FAIL flush_on_xfer cnt=%0d fv=%0b fill=%0d data=%h required all 0",
                     fc_m, fv_m, fl_m, fd_m);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            if (f == 0) feed(1, 20, 1'b1);
            else feed(11 + 10*f, 10, 1'b1);
            check_frame(f == 0 ? "gaps_frame1" : (f == 1 ? "gaps_frame2" : "gaps_frame3"));
            @(negedge clk);
            model_xfer();
        end
        tests++;
        if (fc_m !== 16'd3 || fl_m !== CW'(10) || exp_q.size() != 0) begin
            fails++;
            $display("FAIL gaps_end cnt=%0d fill=%0d pending=%0d required 3,10,0",
                     fc_m, fl_m, exp_q.size());
        end
    endtask

    task automatic test_reset_hold();
        do_reset();
        frame_empty = 1'b0;
        feed(1, 20, 1'b0);
        tests++;
        if (fv_m !== 1'b1) begin
            fails++;
            $display("FAIL rsthold_pre fv=%0b required 1", fv_m);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (fv_m !== 1'b0 || fl_m !== '0 || fd_m !== '0 || rdy_m !== 1'b1) begin
            fails++;
            $display("FAIL rsthold_async fv=%0b fill=%0d rdy=%0b data=%h required 0,0,1 data=0",
                     fv_m, fl_m, rdy_m, fd_m);
        end
        win_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n       = 1'b1;
        frame_empty = 1'b1;
        feed(1, 20, 1'b0);
        check_frame("rsthold_frame_1_20");
        @(negedge clk);
        model_xfer();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        sel   = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        frame_empty = 1'b1;
        test_reset();
        test_basic();
        test_hold();
        test_no_overlap();
        test_flush();
        test_gaps();
        test_reset_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_pack.md
Name: frame_pack

Overview:
- Producer side of the frame interface consumed by fetchnum.
- Collects a serial stream of DW-bit feature samples into a FRAME_LEN-sample frame buffer.
- Offers the complete frame on a flat parallel bus and hands it over when the consumer signals empty.
- Retains the newest FRAME_LEN-HOP samples as overlap for the next frame, giving hop-based framing for VAD.

Parameters:
- DW, 16, sample width in bits.
- FRAME_LEN, 20, samples per frame.
- HOP, 10, new samples per frame after the first. Legal range is 1..FRAME_LEN; HOP=FRAME_LEN means no overlap.
- CW, $clog2(FRAME_LEN+1), width of fill_level.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous restart; discards buffered samples and overlap.
- s_valid  in  1  input sample valid.
- s_data  in  DW  input sample.
- s_ready  out  1  block accepts a sample this cycle.
- frame_empty  in  1  consumer is empty and will capture frame_data at this edge (fetchnum empty).
- frame_valid  out  1  full frame on frame_data (drives fetchnum read_en).
- frame_data  out  FRAME_LEN*DW  element k (1..FRAME_LEN) occupies bits [k*DW-1:(k-1)*DW]. Element 1 is the oldest sample.
- fill_level  out  CW  samples currently held, 0..FRAME_LEN.
- frame_cnt  out  16  frames handed over since reset or flush; wraps at 65535 to 0.

Behaviour:
- Reset values: frame_valid=0, frame_data=0, fill_level=0, frame_cnt=0. State is FILL, so s_ready=1.
- States: FILL and HOLD.
- s_ready = (state==FILL) && !flush. It is combinational from registered state plus flush.
- Sample accept occurs on s_valid && s_ready.
  - The sample is written to element fill_level+1, then fill_level increments.
  - s_valid gaps are allowed; there is no timeout.
- FILL -> HOLD on the edge that accepts the sample making fill_level==FRAME_LEN.
  - frame_valid=1 from the next cycle.
  - Latency from last sample accept to frame_valid is 1 cycle.
- HOLD:
  - s_ready=0.
  - frame_data and frame_valid are held stable until transfer.
- Transfer occurs on an edge where frame_valid && frame_empty.
  - The consumer captures frame_data at the same edge.
  - Next cycle: frame_valid=0 and frame_cnt+1.
  - Buffer shifts: element k <= element k+HOP for k=1..FRAME_LEN-HOP; the upper HOP elements are zeroed.
  - fill_level <= FRAME_LEN-HOP, state -> FILL, and s_ready=1 on that cycle.
- HOP=FRAME_LEN: after transfer, fill_level=0 and the whole buffer is zeroed.
- frame_empty while in FILL is ignored; no transfer occurs and frame_valid stays 0.
- flush has the highest priority over sample accept.
  - Effect: fill_level=0, frame_data=0, frame_valid=0, frame_cnt=0, state FILL.
  - If flush coincides with a transfer edge, the consumer has already captured. The frame is lost to the counter because frame_cnt is cleared, not incremented.
  - s_ready is 0 during the flush cycle, so no sample is lost silently.
- Reset mid-operation (any state) returns immediately to reset values. A partially filled frame is discarded.
- No arithmetic on samples: data passes bit-exact. No sign extension or reordering beyond the documented element positions.

Test Plan:
1. Defaults, frame_empty=1, feed s_data=1..20 back-to-back.
   - frame_valid rises 1 cycle after sample 20 is accepted.
   - Elements 1..20 = 1..20.
   - Transfer on the next edge, frame_cnt=1, fill_level=10.
   - Elements 1..10 = 11..20.
2. Hold frame_empty=0 for 5 cycles with a full frame.
   - s_ready=0 and frame_data unchanged throughout.
   - Raise frame_empty: transfer on that edge.
   - Feed 21..30: next frame = 11..30.
3. HOP=20 instance, feed 1..40 with frame_empty=1.
   - Two frames: 1..20, then 21..40.
   - fill_level=0 after each transfer.
   - frame_cnt=2.
4. Flush after 7 samples (values 1..7), then feed 100..119.
   - Frame = 100..119.
   - frame_cnt=0 before this transfer, 1 after.
5. Random s_valid gaps (~50% duty) over 3 frames, defaults.
   - Frames: 1..20, 11..30, 21..40.
   - No sample dropped or duplicated.
   - frame_cnt=3.
6. Assert rst_n low during HOLD.
   - frame_valid=0, fill_level=0, frame_data=0, s_ready=1 immediately.
   - Feeding 1..20 afterwards yields frame 1..20.
